key_tone: RTL

Note player that consumes the debounced one-cycle key pulses and drives the passive buzzer. A key pulse selects one of seven notes (C4–B4). The block plays a square wave of that pitch for a fixed duration, then holds a short silent gap before returning to idle. It sits directly downstream of the key debouncer, with its `key_pulse` vector wired to this block's `key_pulse` input, and its `beep` output wired to the buzzer pin.

---
 rtl/key_tone_if.sv | 12 +
 rtl/key_tone.sv | 138 +++++++++++++
 2 files changed

// File: rtl/key_tone_if.sv
// Key-pulse / buzzer bundle between the debouncer-facing stimulus side and the note player.
interface key_tone_if #(
  parameter int N = 7
);
  logic [N-1:0] key_pulse;
  logic         beep;
  logic         busy;
  logic [2:0]   note;

  modport master (output key_pulse, input beep, input busy, input note);
  modport slave  (input key_pulse, output beep, output busy, output note);
endinterface

// File: rtl/key_tone.sv
// Seven-note buzzer player: a key pulse starts a square wave of fixed length,
// followed by a silent gap; any new pulse restarts playback immediately.
module key_tone #(
  parameter int N          = 7,
  parameter int NOTE_LEN   = 12_500_000,
  parameter int GAP_LEN    = 1_250_000,
  parameter int TONE_SHIFT = 0
) (
  input  logic     cp,
  input  logic     rst,
  key_tone_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [23:0] NOTE_LAST = 24'(NOTE_LEN - 1);
  localparam logic [23:0] GAP_LAST  = 24'(GAP_LEN - 1);

  // Half-period of each note in cp cycles, scaled down for simulation.
  function automatic logic [16:0] half_period(input logic [2:0] idx);
    logic [16:0] base;
    case (idx)
      3'd0:    base = 17'd95556;
      3'd1:    base = 17'd85132;
      3'd2:    base = 17'd75843;
      3'd3:    base = 17'd71586;
      3'd4:    base = 17'd63776;
      3'd5:    base = 17'd56818;
      3'd6:    base = 17'd50619;
      default: base = 17'd95556;
    endcase
    return base >> TONE_SHIFT;
  endfunction

  state_t      state_r, state_s;
  logic [2:0]  note_r, note_s;
  logic        beep_r, beep_s;
  logic        busy_r, busy_s;
  logic [16:0] hp_cnt_r, hp_cnt_s;
  logic [23:0] dur_cnt_r, dur_cnt_s;
  logic        hit_s;
  logic [2:0]  sel_s;
  logic [16:0] hp_last_s;

  // Lowest-index key wins; scanning downward lets the lowest set bit overwrite.
  always_comb begin
    hit_s = |bus.key_pulse;
    sel_s = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      sel_s = bus.key_pulse[i] ? 3'(i) : sel_s;
    end
  end

  assign hp_last_s = half_period(note_r) - 17'd1;

  // Next-state and next-output logic; a pulse overrides any expiry this cycle.
  always_comb begin
    state_s   = state_r;
    note_s    = note_r;
    beep_s    = 1'b0;
    hp_cnt_s  = hp_cnt_r;
    dur_cnt_s = dur_cnt_r;
    if (hit_s) begin
      state_s   = PLAY;
      note_s    = sel_s;
      beep_s    = 1'b0;
      hp_cnt_s  = 17'd0;
      dur_cnt_s = 24'd0;
    end else begin
      case (state_r)
        IDLE: begin
          beep_s = 1'b0;
        end
        PLAY: begin
          if (dur_cnt_r == NOTE_LAST) begin
            state_s   = GAP;
            beep_s    = 1'b0;
            hp_cnt_s  = 17'd0;
            dur_cnt_s = 24'd0;
          end else begin
            dur_cnt_s = dur_cnt_r + 24'd1;
            if (hp_cnt_r == hp_last_s) begin
              hp_cnt_s = 17'd0;
              beep_s   = ~beep_r;
            end else begin
              hp_cnt_s = hp_cnt_r + 17'd1;
              beep_s   = beep_r;
            end
          end
        end
        GAP: begin
          beep_s = 1'b0;
          if (dur_cnt_r == GAP_LAST) begin
            state_s   = IDLE;
            dur_cnt_s = 24'd0;
          end else begin
            dur_cnt_s = dur_cnt_r + 24'd1;
          end
        end
        default: begin
          state_s   = IDLE;
          beep_s    = 1'b0;
          hp_cnt_s  = 17'd0;
          dur_cnt_s = 24'd0;
        end
      endcase
    end
    busy_s = (state_s != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge cp or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      note_r    <= 3'd0;
      beep_r    <= 1'b0;
      busy_r    <= 1'b0;
      hp_cnt_r  <= 17'd0;
      dur_cnt_r <= 24'd0;
    end else begin
      state_r   <= state_s;
      note_r    <= note_s;
      beep_r    <= beep_s;
      busy_r    <= busy_s;
      hp_cnt_r  <= hp_cnt_s;
      dur_cnt_r <= dur_cnt_s;
    end
  end

  assign bus.beep = beep_r;
  assign bus.busy = busy_r;
  assign bus.note = note_r;

endmodule
